keypad_scan_ctrl: RTL and testbench



---
 rtl/keyscan_pkg.sv | 35 +++
 rtl/sync_2ff.sv | 32 +++
 rtl/keypad_scan_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/keyscan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map,
// column reset pattern and small decode helpers.
package keyscan_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESS    = 2'd2,
      HOLD     = 2'd3
   } state_e;

   // Indexed [row][col]; the last concatenation element is row 0 / col 0.
   localparam logic [3:0][3:0][3:0] KEY_MAP = {
      16'hDF0E,
      16'hC987,
      16'hB654,
      16'hA321
   };

   localparam logic [3:0] COLS_RESET = 4'b1110;

   function automatic logic [1:0] lowest_low(input logic [3:0] r);
      logic [1:0] idx;
      if (!r[0])      idx = 2'd0;
      else if (!r[1]) idx = 2'd1;
      else if (!r[2]) idx = 2'd2;
      else            idx = 2'd3;
      return idx;
   endfunction

   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for the asynchronous keypad row lines.
module sync_2ff #(
   parameter int         W         = 4,
   parameter logic [W-1:0] RESET_VAL = '1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner with press/release debounce and hex decode.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | rotate the low column every SCAN_DIV cycles, look for a low row
// DEBOUNCE | column frozen, count stable-low cycles on the latched row
// PRESS    | one cycle: en high, hexVal and keyHeld updated
// HOLD     | column frozen, wait for a debounced release of the latched row
module keypad_scan_ctrl
   import keyscan_pkg::*;
#(
   parameter int SCAN_DIV  = 1000,
   parameter int DB_CYCLES = 20000
`ifdef KEY_REPEAT_EN
   ,
   parameter int REPEAT_CYCLES = 500000
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic       en,
   output logic [3:0] hexVal,
   output logic       keyHeld
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DB_W  = $clog2(DB_CYCLES);
   localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]  DB_TC  = DB_W'(DB_CYCLES - 1);

   logic [3:0] rs;

   sync_2ff #(.W(4), .RESET_VAL(4'hF)) u_row_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rows),
      .q     (rs)
   );

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic [DB_W-1:0]   rel_cnt_q, rel_cnt_d;
   logic [1:0]        col_idx_q, col_idx_d;
   logic [1:0]        row_idx_q, row_idx_d;
   logic [3:0]        cols_q, cols_d;
   logic              en_q, en_d;
   logic [3:0]        hex_val_q, hex_val_d;
   logic              key_held_q, key_held_d;
   logic              row_high;

`ifdef KEY_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CYCLES);
   localparam logic [REP_W-1:0] REP_TC = REP_W'(REPEAT_CYCLES - 1);
   logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
`endif

   assign row_high = rs[row_idx_q];

   always_comb begin
      state_d    = state_q;
      div_cnt_d  = div_cnt_q;
      db_cnt_d   = db_cnt_q;
      rel_cnt_d  = rel_cnt_q;
      col_idx_d  = col_idx_q;
      row_idx_d  = row_idx_q;
      hex_val_d  = hex_val_q;
      key_held_d = key_held_q;
      en_d       = 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_d  = rep_cnt_q;
`endif

      case (state_q)
         SCAN: begin
            if (div_cnt_q == DIV_TC) begin
               div_cnt_d = '0;
               if (rs != 4'hF) begin
                  row_idx_d = lowest_low(rs);
                  db_cnt_d  = '0;
                  state_d   = DEBOUNCE;
               end else begin
                  col_idx_d = 2'(col_idx_q + 2'd1);
               end
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end

         DEBOUNCE: begin
            if (row_high) begin
               state_d   = SCAN;
               col_idx_d = 2'(col_idx_q + 2'd1);
               db_cnt_d  = '0;
               div_cnt_d = '0;
            end else if (db_cnt_q == DB_TC) begin
               state_d    = PRESS;
               db_cnt_d   = '0;
               rel_cnt_d  = '0;
               en_d       = 1'b1;
               hex_val_d  = KEY_MAP[row_idx_q][col_idx_q];
               key_held_d = 1'b1;
`ifdef KEY_REPEAT_EN
               rep_cnt_d  = '0;
`endif
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end

         PRESS: begin
            state_d = HOLD;
`ifdef KEY_REPEAT_EN
            // The press cycle counts toward the first repeat interval.
            rep_cnt_d = rep_cnt_q + 1'b1;
`endif
         end

         HOLD: begin
            if (row_high) begin
`ifdef KEY_REPEAT_EN
               rep_cnt_d = '0;
`endif
               if (rel_cnt_q == DB_TC) begin
                  state_d    = SCAN;
                  key_held_d = 1'b0;
                  rel_cnt_d  = '0;
                  div_cnt_d  = '0;
                  col_idx_d  = 2'(col_idx_q + 2'd1);
               end else begin
                  rel_cnt_d = rel_cnt_q + 1'b1;
               end
            end else begin
               rel_cnt_d = '0;
`ifdef KEY_REPEAT_EN
               if (rep_cnt_q == REP_TC) begin
                  en_d      = 1'b1;
                  rep_cnt_d = '0;
               end else begin
                  rep_cnt_d = rep_cnt_q + 1'b1;
               end
`endif
            end
         end

         default: state_d = SCAN;
      endcase

      cols_d = col_drive(col_idx_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= SCAN;
         div_cnt_q  <= '0;
         db_cnt_q   <= '0;
         rel_cnt_q  <= '0;
         col_idx_q  <= 2'd0;
         row_idx_q  <= 2'd0;
         cols_q     <= COLS_RESET;
         en_q       <= 1'b0;
         hex_val_q  <= 4'h0;
         key_held_q <= 1'b0;
`ifdef KEY_REPEAT_EN
         rep_cnt_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         db_cnt_q   <= db_cnt_d;
         rel_cnt_q  <= rel_cnt_d;
         col_idx_q  <= col_idx_d;
         row_idx_q  <= row_idx_d;
         cols_q     <= cols_d;
         en_q       <= en_d;
         hex_val_q  <= hex_val_d;
         key_held_q <= key_held_d;
`ifdef KEY_REPEAT_EN
         rep_cnt_q  <= rep_cnt_d;
`endif
      end
   end

   assign cols    = cols_q;
   assign en      = en_q;
   assign hexVal  = hex_val_q;
   assign keyHeld = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl with a behavioural 4x4 key matrix;
// the auto-repeat scenario runs only when KEY_REPEAT_EN is defined.
module tb_keypad_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] rows;
   logic [3:0] cols;
   logic       en;
   logic [3:0] hexVal;
   logic       keyHeld;

   logic [15:0] pressed;   // bit r*4+c = key at row r, column c is down

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int en_count = 0;
   logic prev_en = 1'b0;

   logic [3:0] exp_q[$];
   int         en_times[$];

   keypad_scan_ctrl #(
      .SCAN_DIV  (4),
      .DB_CYCLES (8)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_CYCLES (20)
`endif
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .rows    (rows),
      .cols    (cols),
      .en      (en),
      .hexVal  (hexVal),
      .keyHeld (keyHeld)
   );

   always #5 clk = ~clk;

   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_held(input logic val, input int bound, output int waited);
      waited = 0;
      while (keyHeld !== val && waited < bound) begin
         @(negedge clk);
         waited++;
      end
      if (keyHeld !== val) begin
         checks++;
         failures++;
         $display("FAIL wait_keyHeld_%0b actual=timeout required=within_%0d_cycles", val, bound);
      end
   endtask

   // Monitor: every en pulse is matched against the scoreboard queue.
   always @(negedge clk) begin
      cyc++;
      if (!reset && en === 1'b1) begin
         en_count++;
         en_times.push_back(cyc);
         check("en_not_back_to_back", {31'd0, prev_en}, 32'd0);
         check("keyHeld_at_en", {31'd0, keyHeld}, 32'd1);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_en actual=hexVal_%0h required=no_en", hexVal);
         end else begin
            check("en_hexVal", {28'd0, hexVal}, {28'd0, exp_q.pop_front()});
         end
      end
      prev_en = reset ? 1'b0 : en;
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] col_seq [4];
      logic [3:0] prev_cols;
      logic       frozen_ok;
      int w, k, e0;
      col_seq[0] = 4'b1110;
      col_seq[1] = 4'b1101;
      col_seq[2] = 4'b1011;
      col_seq[3] = 4'b0111;

      // 1. reset
      reset   = 1'b1;
      pressed = '0;
      tick(3);
      check("rst_cols", {28'd0, cols}, 32'b1110);
      check("rst_en", {31'd0, en}, 32'd0);
      check("rst_hexVal", {28'd0, hexVal}, 32'd0);
      check("rst_keyHeld", {31'd0, keyHeld}, 32'd0);
      reset = 1'b0;

      // 2. idle scan, each column held 4 cycles
      for (int s = 0; s < 20; s++) begin
         check($sformatf("idle_cols_s%0d", s), {28'd0, cols}, {28'd0, col_seq[(s/4)%4]});
         tick(1);
      end

      // 3. key row1/col2 -> 6
      e0 = en_count;
      exp_q.push_back(4'h6);
      pressed[1*4+2] = 1'b1;
      wait_held(1'b1, 100, w);
      frozen_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (cols !== 4'b1011) frozen_ok = 1'b0;
         tick(1);
      end
      check("hold_cols_frozen", {31'd0, frozen_ok}, 32'd1);
      pressed = '0;
      k = 0;
      for (int i = 1; i <= 30; i++) begin
         tick(1);
         if (keyHeld === 1'b0) begin
            k = i;
            break;
         end
      end
      check("release_latency", k, 32'd10);
      check("resume_cols", {28'd0, cols}, 32'b0111);
      check("hexVal_holds", {28'd0, hexVal}, 32'h6);
      check("t3_en_count", en_count - e0, 32'd1);

      // 4. bouncing row3/col3 -> D
      e0 = en_count;
      exp_q.push_back(4'hD);
      for (int i = 0; i < 10; i++) begin
         pressed[15] = (i % 2 == 0);
         tick(3);
      end
      pressed[15] = 1'b1;
      wait_held(1'b1, 100, w);
      tick(20);
      pressed = '0;
      wait_held(1'b0, 100, w);
      check("t4_en_count", en_count - e0, 32'd1);

      // 5. short glitch on row0 at the start of column 0
      e0 = en_count;
      prev_cols = cols;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (cols === 4'b1110 && prev_cols === 4'b0111) break;
         prev_cols = cols;
      end
      check("sync_to_col0", {28'd0, cols}, 32'b1110);
      pressed[0] = 1'b1;
      tick(5);
      pressed[0] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (cols !== 4'b1110) break;
         tick(1);
      end
      check("glitch_next_cols", {28'd0, cols}, 32'b1101);
      tick(10);
      check("glitch_no_en", en_count - e0, 32'd0);

      // rows 0 and 2 together on column 0 -> lowest row wins -> 1
      exp_q.push_back(4'h1);
      pressed[0] = 1'b1;
      pressed[8] = 1'b1;
      wait_held(1'b1, 100, w);
      tick(20);
      check("multi_key_hexVal", {28'd0, hexVal}, 32'h1);
      pressed = '0;
      wait_held(1'b0, 100, w);
      check("t5_en_count", en_count - e0, 32'd1);

      // 6. reset during HOLD
      exp_q.push_back(4'h9);
      pressed[10] = 1'b1;
      wait_held(1'b1, 100, w);
      tick(2);
      reset   = 1'b1;
      pressed = '0;
      tick(1);
      check("hold_rst_cols", {28'd0, cols}, 32'b1110);
      check("hold_rst_keyHeld", {31'd0, keyHeld}, 32'd0);
      check("hold_rst_en", {31'd0, en}, 32'd0);
      check("hold_rst_hexVal", {28'd0, hexVal}, 32'd0);
      reset = 1'b0;
      tick(2);

`ifdef KEY_REPEAT_EN
      en_times.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(4'h9);
      pressed[10] = 1'b1;
      wait_held(1'b1, 100, w);
      tick(70);
      pressed = '0;
      wait_held(1'b0, 100, w);
      check("repeat_count", en_times.size(), 32'd4);
      for (int i = 1; i < 4; i++)
         if (i < en_times.size())
            check($sformatf("repeat_gap_%0d", i), en_times[i] - en_times[i-1], 32'd20);
`endif

      tick(5);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
